array_count_less_unit: RTL and testbench

- Multi-cycle engine that executes the arrayCountLess instruction against the single-port heap memory.
- Counts the elements of one heap array that are unsigned-less-than a key.
- Sits between the instruction sequencer (upstream: start, array, size, key) and heapMemory (downstream: address, read strobe, read data).
- Replaces the single-cycle combinational scan of the heap with a pipelined sequential read, one element per clock.

---
 rtl/array_count_less_unit_if.sv | 32 +++
 rtl/array_count_less_unit.sv | 105 ++++++++++
 tb/tb_array_count_less_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/array_count_less_unit_if.sv
// array_count_less_unit_if: bundles the sequencer request/response signals and
// the heap read port of the arrayCountLess engine.
//   start/array/size/key : request from the instruction sequencer
//   busy/done/count      : status and result back to the sequencer
//   heapAddress/heapRead : read request to heapMemory
//   heapOut              : heap read data, one cycle after the request
// slave  = engine view, master = sequencer + heap view.
interface array_count_less_unit_if #(
   parameter int MemoryElementWidth = 12,
   parameter int HeapAddressWidth   = 12
);
   logic                          start;
   logic [MemoryElementWidth-1:0] array;
   logic [MemoryElementWidth-1:0] size;
   logic [MemoryElementWidth-1:0] key;
   logic                          busy;
   logic                          done;
   logic [MemoryElementWidth-1:0] count;
   logic [HeapAddressWidth-1:0]   heapAddress;
   logic                          heapRead;
   logic [MemoryElementWidth-1:0] heapOut;

   modport slave (
      input  start, array, size, key, heapOut,
      output busy, done, count, heapAddress, heapRead
   );

   modport master (
      output start, array, size, key, heapOut,
      input  busy, done, count, heapAddress, heapRead
   );
endinterface

// File: rtl/array_count_less_unit.sv
// array_count_less_unit: counts the elements of one heap array that are
// unsigned-less-than a key, reading the heap one element per clock.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of array_count_less_unit_if (request, status, heap port)
// Timeline for n = min(size, NArea): start sampled in cycle 0, reads in
// cycles 1..n, last compare in the DRAIN cycle n+1, done pulse in cycle n+2.
module array_count_less_unit #(
   parameter int MemoryElementWidth = 12,
   parameter int NArea              = 4,
   parameter int HeapAddressWidth   = 12
) (
   input  logic                     clock,
   input  logic                     reset,
   array_count_less_unit_if.slave   bus
);
   localparam int MEW = MemoryElementWidth;
   localparam int HAW = HeapAddressWidth;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t           state_q, state_d;
   logic [MEW-1:0]   key_q, key_d;
   logic [MEW-1:0]   n_q, n_d;
   logic [MEW-1:0]   i_q, i_d;
   logic [HAW-1:0]   addr_q, addr_d;
   logic [MEW-1:0]   acc_q, acc_d;
   logic [MEW-1:0]   count_q, count_d;
   // Marks the cycle after a read, when heapOut carries that read's data.
   logic             rdv_q;

   logic             hit;
   logic [MEW-1:0]   acc_inc;
   logic [HAW-1:0]   base;

   assign hit     = rdv_q && (bus.heapOut < key_q);
   assign acc_inc = acc_q + MEW'(hit);
   // Area base truncated to the address width; the per-element increment of
   // addr_q wraps the same way, giving (array*NArea + i) mod 2^HAW.
   assign base    = HAW'(bus.array) * HAW'(NArea);

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      n_d     = n_q;
      i_d     = i_q;
      addr_d  = addr_q;
      acc_d   = acc_inc;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               key_d   = bus.key;
               n_d     = (bus.size > MEW'(NArea)) ? MEW'(NArea) : bus.size;
               i_d     = '0;
               acc_d   = '0;
               addr_d  = base;
               state_d = (n_d != '0) ? SCAN : DRAIN;
            end
         end
         SCAN: begin
            if (i_q == n_q - MEW'(1)) begin
               state_d = DRAIN;   // address holds on the last element
            end else begin
               i_d    = i_q + MEW'(1);
               addr_d = addr_q + HAW'(1);
            end
         end
         DRAIN: begin
            state_d = DONE;
            count_d = acc_inc;   // include the final compare
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         n_q     <= '0;
         i_q     <= '0;
         addr_q  <= '0;
         acc_q   <= '0;
         count_q <= '0;
         rdv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         n_q     <= n_d;
         i_q     <= i_d;
         addr_q  <= addr_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         rdv_q   <= (state_q == SCAN);
      end
   end

   assign bus.busy        = (state_q == SCAN) || (state_q == DRAIN);
   assign bus.done        = (state_q == DONE);
   assign bus.heapRead    = (state_q == SCAN);
   assign bus.heapAddress = addr_q;
   assign bus.count       = count_q;
endmodule

// File: tb/tb_array_count_less_unit.sv
module tb_array_count_less_unit;
   localparam int NA = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [11:0] heap [4096];

   array_count_less_unit_if #(.MemoryElementWidth(12), .HeapAddressWidth(12)) bus ();

   array_count_less_unit #(
      .MemoryElementWidth(12), .NArea(NA), .HeapAddressWidth(12)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Heap memory model: samples the address at the edge ending a read cycle.
   always @(posedge clock) if (bus.heapRead) bus.heapOut <= heap[bus.heapAddress];

   typedef struct {
      logic [11:0] a;
      logic [11:0] s;
      logic [11:0] k;
      int          exp_cnt;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic int model(input logic [11:0] a, input logic [11:0] s, input logic [11:0] k);
      int n = (s > NA) ? NA : int'(s);
      int c = 0;
      for (int i = 0; i < n; i++) begin
         logic [11:0] ad = 12'(int'(a) * NA + i);
         if (heap[ad] < k) c++;
      end
      return c;
   endfunction

   // One operation: start in cycle 0, watch cycles 1.. until done or budget.
   // Inputs are scrambled after acceptance; optional stray start at glitch_cyc.
   task automatic run_op(input logic [11:0] a, input logic [11:0] s, input logic [11:0] k,
                         input int glitch_cyc, input string nm, input int exp_cnt);
      int n = (s > NA) ? NA : int'(s);
      int done_cyc = -1, nrd = 0, bad_addr = 0, bad_busy = 0;
      logic [11:0] cnt = '0;
      @(posedge clock); #1;
      bus.start = 1'b1; bus.array = a; bus.size = s; bus.key = k;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock); #1;
         bus.start = (c == glitch_cyc);
         bus.array = 12'($urandom); bus.size = 12'($urandom); bus.key = 12'($urandom);
         if (bus.heapRead) begin
            if (bus.heapAddress != 12'(int'(a) * NA + nrd)) bad_addr++;
            nrd++;
         end
         if (bus.busy != (c <= n + 1)) bad_busy++;
         if (bus.done) begin
            done_cyc = c;
            cnt = bus.count;
            break;
         end
      end
      bus.start = 1'b0;
      chk({nm, "_done_cycle"}, done_cyc, n + 2);
      chk({nm, "_count"}, int'(cnt), exp_cnt);
      chk({nm, "_reads"}, nrd, n);
      chk({nm, "_addr_errs"}, bad_addr, 0);
      chk({nm, "_busy_errs"}, bad_busy, 0);
      @(posedge clock); #1;
      chk({nm, "_done_pulse"}, int'(bus.done), 0);
      chk({nm, "_count_held"}, int'(bus.count), exp_cnt);
   endtask

   initial begin
      vec_t tbl[8];
      int extra;

      for (int i = 0; i < 4096; i++) heap[i] = '0;
      heap[0] = 12'd10; heap[1] = 12'd20; heap[2] = 12'd30; heap[3] = 12'd7;
      heap[4] = 12'd1;  // just past area 0, must never be read
      heap[8] = 12'd1; heap[9] = 12'd2; heap[10] = 12'd3; heap[11] = 12'd4;
      heap[12] = 12'd0;

      tbl[0] = '{12'd0, 12'd3, 12'd20,   1};
      tbl[1] = '{12'd0, 12'd0, 12'd20,   0};
      tbl[2] = '{12'd2, 12'd6, 12'd100,  4};
      tbl[3] = '{12'd0, 12'd3, 12'd0,    0};
      tbl[4] = '{12'd0, 12'd3, 12'd4095, 3};
      tbl[5] = '{12'd0, 12'd7, 12'd20,   2};
      tbl[6] = '{12'd0, 12'd1, 12'd11,   1};
      tbl[7] = '{12'd0, 12'd3, 12'd30,   2};

      bus.start = 1'b0; bus.array = '0; bus.size = '0; bus.key = '0;
      #12;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_count", int'(bus.count), 0);
      chk("rst_addr", int'(bus.heapAddress), 0);
      chk("rst_read", int'(bus.heapRead), 0);
      @(posedge clock); #1; reset = 1'b1;

      for (int t = 0; t < 8; t++)
         run_op(tbl[t].a, tbl[t].s, tbl[t].k, -1, $sformatf("vec%0d", t), tbl[t].exp_cnt);

      // Stray start during an active scan: ignored, single done.
      run_op(12'd0, 12'd3, 12'd20, 2, "stray_start", 1);
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clock); #1;
         if (bus.done) extra++;
      end
      chk("stray_no_2nd_done", extra, 0);

      // Reset mid-scan: immediate abort, no done, fresh run afterwards.
      @(posedge clock); #1;
      bus.start = 1'b1; bus.array = 12'd0; bus.size = 12'd3; bus.key = 12'd20;
      @(posedge clock); #1; bus.start = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0; #1;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_read", int'(bus.heapRead), 0);
      chk("abort_count", int'(bus.count), 0);
      chk("abort_done", int'(bus.done), 0);
      extra = 0;
      @(posedge clock); @(posedge clock); #1; reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clock); #1;
         if (bus.done || bus.busy || bus.heapRead) extra++;
      end
      chk("abort_quiet", extra, 0);
      run_op(12'd0, 12'd3, 12'd20, -1, "after_reset", 1);

      // Randomized operations against the reference model.
      for (int r = 0; r < 25; r++) begin
         logic [11:0] a = 12'($urandom);
         logic [11:0] s = 12'($urandom_range(0, 7));
         logic [11:0] k = 12'($urandom_range(0, 16));
         for (int i = 0; i < NA + 2; i++) heap[12'(int'(a) * NA + i)] = 12'($urandom_range(0, 15));
         run_op(a, s, k, (r % 3 == 0) ? 1 : -1, $sformatf("rnd%0d", r), model(a, s, k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
